prog_counter: RTL and testbench

Parametrised, programmable successor to the team's fixed 4-bit counter. Adds configurable width, up/down direction, programmable limit (modulo), a prescaler, parallel load, three terminal modes (wrap, one-shot, saturate) and a small run-control FSM. Used as a general timer/event counter in peripheral and testbench infrastructure.

---
 rtl/prog_counter_pkg.sv | 7 +
 rtl/prog_counter_if.sv | 11 +
 rtl/prog_counter_presc.sv | 17 +
 rtl/prog_counter.sv | 56 +++++
 tb/tb_prog_counter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared mode/state types and direction constants for prog_counter
package prog_counter_pkg;
  typedef enum logic [1:0] {MODE_WRAP = 2'd0, MODE_ONESHOT = 2'd1, MODE_SAT = 2'd2} mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_e;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/prog_counter_if.sv
// prog_counter_if: control and status bundle between a counter user (master) and prog_counter (slave)
interface prog_counter_if #(parameter int WIDTH = 8, parameter int PRESC_W = 4);
  logic enable, load, dir, capture, tick, busy, done;
  logic [WIDTH-1:0] load_val, limit, count, cap_val;
  logic [1:0] mode;
  logic [PRESC_W-1:0] prescale;
  modport master(output enable, load, load_val, limit, dir, mode, prescale, capture,
                 input count, tick, busy, done, cap_val);
  modport slave(input enable, load, load_val, limit, dir, mode, prescale, capture,
                output count, tick, busy, done, cap_val);
endinterface

// File: rtl/prog_counter_presc.sv
// prog_counter_presc: divides enabled run cycles by prescale+1 and emits the count step strobe
module prog_counter_presc #(parameter int PRESC_W = 4) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescale,
  output logic               step
);
  logic [PRESC_W-1:0] presc_cnt;
  assign step = run && presc_cnt == prescale;
  // count enabled run cycles, restarting after each step or on a load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) presc_cnt <= '0;
    else if (clr) presc_cnt <= '0;
    else if (run) presc_cnt <= step ? '0 : presc_cnt + 1'b1;
endmodule

// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with prescaler, load, wrap/one-shot/saturate modes; PROG_COUNTER_CAPTURE_EN adds a count snapshot register
module prog_counter
  import prog_counter_pkg::*;
#(parameter int WIDTH = 8, parameter int PRESC_W = 4) (
  input logic clk,
  input logic rst_n,
  prog_counter_if.slave bus
);
  state_e state, state_nx;
  logic step, term, stop, run, tick_q;
  logic [WIDTH-1:0] count_q;
  assign run = state == ST_RUN && bus.enable;
  assign term = bus.dir == DIR_DOWN ? count_q == '0 : count_q >= bus.limit;
  assign stop = bus.mode == MODE_ONESHOT || bus.mode == MODE_SAT;
  assign bus.count = count_q;
  assign bus.tick = tick_q;
  assign bus.busy = state == ST_RUN;
  assign bus.done = state == ST_HALT;
  prog_counter_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(bus.load), .prescale(bus.prescale), .step(step)
  );
  // run control: HALT is left only through a load
  always_comb
    state_nx = state == ST_IDLE ? (bus.enable ? ST_RUN : ST_IDLE)
             : state == ST_RUN  ? (!bus.enable ? ST_IDLE : (step && term && stop && !bus.load) ? ST_HALT : ST_RUN)
             : bus.load ? (bus.enable ? ST_RUN : ST_IDLE) : ST_HALT;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  // count datapath: load beats a step; terminal steps reload or hold and pulse tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= '0;
      tick_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_val;
      tick_q <= 1'b0;
    end else begin
      tick_q <= step && term;
      if (step)
        count_q <= !term ? (bus.dir == DIR_DOWN ? count_q - 1'b1 : count_q + 1'b1)
                 : bus.mode == MODE_SAT ? count_q
                 : bus.dir == DIR_DOWN ? bus.limit : '0;
    end
`ifdef PROG_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;
  assign bus.cap_val = cap_q;
  // snapshot of the pre-edge count on a capture strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cap_q <= '0;
    else if (bus.capture) cap_q <= count_q;
`else
  assign bus.cap_val = '0;
`endif
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed and randomized checks of prog_counter against a behavioural model
module tb_prog_counter;
  localparam int CW = 4;
  localparam int PW = 4;
  localparam int CM = 1 << CW;
  localparam int PM = 1 << PW;
  logic clk, rst_n;
  int n_chk = 0, n_fail = 0;
  int m_cnt, m_pc, m_st, m_tick, m_cap;
  prog_counter_if #(.WIDTH(CW), .PRESC_W(PW)) bus();
  prog_counter #(.WIDTH(CW), .PRESC_W(PW)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_pc = 0; m_st = 0; m_tick = 0; m_cap = 0;
  endtask
  task automatic model_edge();
    bit fire, hit;
    int nst, lim;
    lim = int'(bus.limit);
    fire = m_st == 1 && bus.enable && m_pc == int'(bus.prescale);
    hit = fire && !bus.load && (bus.dir ? m_cnt == 0 : m_cnt >= lim);
    if (m_st == 0) nst = bus.enable ? 1 : 0;
    else if (m_st == 1) nst = !bus.enable ? 0 : (hit && (bus.mode == 1 || bus.mode == 2)) ? 2 : 1;
    else nst = bus.load ? (bus.enable ? 1 : 0) : 2;
`ifdef PROG_COUNTER_CAPTURE_EN
    if (bus.capture) m_cap = m_cnt;
`endif
    if (bus.load) begin
      m_cnt = int'(bus.load_val); m_pc = 0; m_tick = 0;
    end else begin
      if (m_st == 1 && bus.enable) m_pc = fire ? 0 : (m_pc + 1) % PM;
      m_tick = hit;
      if (hit) m_cnt = bus.mode == 2 ? m_cnt : bus.dir ? lim : 0;
      else if (fire) m_cnt = bus.dir ? (m_cnt + CM - 1) % CM : (m_cnt + 1) % CM;
    end
    m_st = nst;
  endtask
  task automatic check_all(input string tag);
    check({tag, ".count"}, bus.count, m_cnt);
    check({tag, ".tick"}, bus.tick, m_tick);
    check({tag, ".busy"}, bus.busy, m_st == 1);
    check({tag, ".done"}, bus.done, m_st == 2);
    check({tag, ".cap"}, bus.cap_val, m_cap);
  endtask
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.enable = 0; bus.load = 0; bus.load_val = 0; bus.limit = 9; bus.dir = 0;
    bus.mode = 0; bus.prescale = 0; bus.capture = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", bus.count, 0);
    check("rst.tick", bus.tick, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.cap", bus.cap_val, 0);
    rst_n = 1'b1;
    bus.enable = 1;
    for (int i = 0; i < 11; i++) cyc("up_wrap");
    check("up_wrap.end_count", bus.count, 0);
    check("up_wrap.end_tick", bus.tick, 1);
    check("up_wrap.end_busy", bus.busy, 1);
    cyc("up_wrap.after");
    bus.enable = 0; bus.dir = 1; bus.mode = 1; bus.limit = 5; bus.load_val = 2; bus.load = 1;
    cyc("oneshot.load");
    bus.load = 0; bus.enable = 1;
    for (int i = 0; i < 4; i++) cyc("oneshot.run");
    check("oneshot.reload_count", bus.count, 5);
    check("oneshot.reload_tick", bus.tick, 1);
    check("oneshot.done", bus.done, 1);
    for (int i = 0; i < 3; i++) cyc("oneshot.halt");
    check("oneshot.hold_count", bus.count, 5);
    bus.load = 1; bus.load_val = 2;
    cyc("oneshot.rearm");
    check("oneshot.rearm_busy", bus.busy, 1);
    bus.load_val = 0; bus.mode = 2; bus.dir = 0; bus.limit = 3; bus.prescale = 2;
    cyc("sat.load");
    bus.load = 0;
    for (int i = 0; i < 12; i++) cyc("sat.run");
    check("sat.count", bus.count, 3);
    check("sat.done", bus.done, 1);
    for (int i = 0; i < 6; i++) cyc("sat.halt");
    bus.load = 1; bus.load_val = 7; bus.mode = 0; bus.limit = 7; bus.prescale = 0;
    cyc("ldterm.pre");
    bus.load_val = 3;
    cyc("ldterm.hit");
    check("ldterm.count", bus.count, 3);
    check("ldterm.tick", bus.tick, 0);
    bus.load = 0;
    cyc("ldterm.next");
    check("ldterm.next_count", bus.count, 4);
    bus.load = 1; bus.load_val = 5;
    cyc("rst_mid.load");
    bus.load = 0;
    cyc("rst_mid.run");
    check("rst_mid.pre_count", bus.count, 6);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid.count", bus.count, 0);
    check("rst_mid.tick", bus.tick, 0);
    check("rst_mid.busy", bus.busy, 0);
    check("rst_mid.done", bus.done, 0);
    @(posedge clk);
    #1;
    bus.enable = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst_mid.idle");
    bus.enable = 1;
    for (int i = 0; i < 3; i++) cyc("rst_mid.resume");
    check("rst_mid.resume_count", bus.count, 2);
    bus.load = 1; bus.load_val = 4; bus.enable = 0;
    cyc("cap.load");
    bus.load = 0; bus.capture = 1;
    cyc("cap.snap");
    bus.capture = 0;
`ifdef PROG_COUNTER_CAPTURE_EN
    check("cap.value", bus.cap_val, 4);
`else
    check("cap.value", bus.cap_val, 0);
`endif
    bus.load = 1; bus.load_val = 9; bus.capture = 1;
    cyc("cap.with_load");
    bus.load = 0; bus.capture = 0;
    check("cap.with_load_count", bus.count, 9);
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        bus.dir = 1'($urandom);
        bus.mode = 2'($urandom);
        bus.limit = CW'($urandom);
        bus.prescale = PW'($urandom_range(0, 3));
      end
      bus.enable = ($urandom % 8) != 0;
      bus.load = ($urandom % 20) == 0;
      bus.load_val = CW'($urandom);
      bus.capture = ($urandom % 4) == 0;
      cyc("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
